// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code constants and conversion helpers
package gray_pkg;
    localparam int WIDTH_DEF = 4;
    localparam int GRAY_MAX_W = 16;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction
endpackage

// File: rtl/gray_enc.sv
// gray_enc: combinational binary-to-Gray encoder
module gray_enc #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down binary counter with registered Gray output, load and saturate/wrap modes
module gray_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);
    logic [WIDTH-1:0] next_bin;
    logic [WIDTH-1:0] next_gray;
    logic             boundary;
    logic             step;
    logic             next_wrap;

    always_comb begin
        boundary  = up_dn ? (bin_out == '1) : (bin_out == '0);
        step      = en && !(sat && boundary);
        next_bin  = load ? load_val :
                    step ? (up_dn ? bin_out + WIDTH'(1) : bin_out - WIDTH'(1)) : bin_out;
        next_wrap = !load && en && !sat && boundary;
    end

    // Gray is encoded from the next binary value so both outputs register together
    gray_enc #(.WIDTH(WIDTH)) u_enc (
        .bin  (next_bin),
        .gray (next_gray)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_out  <= '0;
            gray_out <= '0;
            wrap     <= 1'b0;
        end else begin
            bin_out  <= next_bin;
            gray_out <= next_gray;
            wrap     <= next_wrap;
        end
    end
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: randomized and directed checks of gray_counter at WIDTH 4 and 8
module tb_gray_counter;
    logic       clk = 1'b0;
    logic       rst, en, up_dn, sat, load;
    logic [3:0] load_val4, bin4, gray4;
    logic [7:0] load_val8, bin8, gray8;
    logic       wrap4, wrap8;
    int total = 0, bad = 0;
    int m4 = 0, m8 = 0;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
        .load_val(load_val4), .bin_out(bin4), .gray_out(gray4), .wrap(wrap4)
    );
    gray_counter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .sat(sat), .load(load),
        .load_val(load_val8), .bin_out(bin8), .gray_out(gray8), .wrap(wrap8)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_next(input int cur, input int top, input int lv);
        if (load) return lv;
        if (!en) return cur;
        if (up_dn) return (cur == top) ? (sat ? cur : 0) : cur + 1;
        return (cur == 0) ? (sat ? cur : top) : cur - 1;
    endfunction

    function automatic bit model_wrap(input int cur, input int top);
        return !load && en && !sat && (up_dn ? cur == top : cur == 0);
    endfunction

    task automatic tick();
        int n4, n8, pg4, pg8;
        bit w4, w8, ld;
        n4 = model_next(m4, 15, load_val4);
        n8 = model_next(m8, 255, load_val8);
        w4 = model_wrap(m4, 15);
        w8 = model_wrap(m8, 255);
        ld = load;
        pg4 = gray4;
        pg8 = gray8;
        @(posedge clk);
        #1;
        check("bin4", bin4, n4);
        check("gray4", gray4, n4 ^ (n4 >> 1));
        check("wrap4", wrap4, w4);
        check("bin8", bin8, n8);
        check("gray8", gray8, n8 ^ (n8 >> 1));
        check("wrap8", wrap8, w8);
        if (!ld) begin
            check("flip4", $countones(gray4 ^ pg4[3:0]), (n4 != m4) ? 1 : 0);
            check("flip8", $countones(gray8 ^ pg8[7:0]), (n8 != m8) ? 1 : 0);
        end
        m4 = n4;
        m8 = n8;
    endtask

    initial begin
        rst = 1'b1; en = 0; up_dn = 1; sat = 0; load = 0; load_val4 = 0; load_val8 = 0;
        #12;
        check("rst_bin4", bin4, 0);
        check("rst_gray4", gray4, 0);
        check("rst_wrap4", wrap4, 0);
        check("rst_bin8", bin8, 0);
        rst = 1'b0;
        // full up-count wrap at WIDTH 4
        en = 1; up_dn = 1; sat = 0;
        repeat (17) tick();
        check("up17_bin4", bin4, 1);
        // asynchronous reset mid-count at 9
        en = 0; load = 1; load_val4 = 5; tick();
        load = 0; en = 1; repeat (4) tick();
        check("pre_rst_bin4", bin4, 9);
        #3 rst = 1'b1;
        #1;
        check("async_bin4", bin4, 0);
        check("async_gray4", gray4, 0);
        check("async_wrap4", wrap4, 0);
        #1 rst = 1'b0;
        m4 = 0; m8 = 0;
        tick();
        check("resume_bin4", bin4, 1);
        // wrap-down
        en = 0; load = 1; load_val4 = 1; up_dn = 0; tick();
        load = 0; en = 1; tick(); tick();
        check("down_bin4", bin4, 15);
        check("down_gray4", gray4, 4'b1000);
        // saturation
        sat = 1; up_dn = 1; en = 0; load = 1; load_val4 = 14; tick();
        load = 0; en = 1; repeat (3) tick();
        check("sat_gray4", gray4, 4'b1000);
        // load beats enable
        load = 1; load_val4 = 6; tick();
        check("prio_gray4", gray4, 4'b0101);
        // 8-bit wrap from 250
        load = 1; load_val8 = 250; sat = 0; tick();
        load = 0; up_dn = 1; repeat (10) tick();
        check("w8_bin8", bin8, 4);
        // random traffic
        repeat (400) begin
            en = $urandom_range(0, 3) != 0;
            up_dn = $urandom_range(0, 1);
            sat = $urandom_range(0, 1);
            load = $urandom_range(0, 15) == 0;
            load_val4 = 4'($urandom);
            load_val8 = 8'($urandom);
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
